// File: rtl/eth_idma_cfg_pkg.sv
// eth_idma_cfg_pkg
// Shared definitions for the Ethernet iDMA configuration register block:
// default bus/iDMA widths, register offsets, STATUS bit positions, the
// handshake FSM state type and the bus / iDMA request struct typedefs.
package eth_idma_cfg_pkg;

    localparam int unsigned DefAddrWidth  = 64;
    localparam int unsigned DefTFLenWidth = 32;
    localparam int unsigned DefRegAw      = 32;
    localparam int unsigned DefRegDw      = 32;

    // Register byte offsets
    localparam logic [7:0] OFF_MAC_LO    = 8'h00;
    localparam logic [7:0] OFF_MAC_HI    = 8'h04;
    localparam logic [7:0] OFF_SRC_ADDR  = 8'h10;
    localparam logic [7:0] OFF_DST_ADDR  = 8'h14;
    localparam logic [7:0] OFF_LENGTH    = 8'h18;
    localparam logic [7:0] OFF_SRC_PROT  = 8'h1c;
    localparam logic [7:0] OFF_DST_PROT  = 8'h20;
    localparam logic [7:0] OFF_REQ_VALID = 8'h38;
    localparam logic [7:0] OFF_REQ_READY = 8'h3c;
    localparam logic [7:0] OFF_RSP_READY = 8'h40;
    localparam logic [7:0] OFF_STATUS    = 8'h44;
    localparam logic [7:0] OFF_XFER_CNT  = 8'h48;

    // STATUS bit indices
    localparam int unsigned STATUS_DONE_BIT = 0;
    localparam int unsigned STATUS_ERR_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } cfg_state_e;

    typedef struct packed {
        logic [DefRegAw-1:0]   addr;
        logic                  write;
        logic [DefRegDw-1:0]   wdata;
        logic [DefRegDw/8-1:0] wstrb;
        logic                  valid;
    } reg_req_t;

    typedef struct packed {
        logic [DefRegDw-1:0] rdata;
        logic                error;
        logic                ready;
    } reg_rsp_t;

    typedef struct packed {
        logic [DefAddrWidth-1:0]  src_addr;
        logic [DefAddrWidth-1:0]  dst_addr;
        logic [DefTFLenWidth-1:0] length;
        logic [2:0]               src_protocol;
        logic [2:0]               dst_protocol;
    } idma_req_t;

endpackage

// File: rtl/eth_idma_cfg_handshake.sv
// eth_idma_cfg_handshake
// Launch / request / response sequencing towards the iDMA engine.
// Ports:
//   s_clk, s_rst_n      clock, asynchronous active-high reset
//   i_launch            software launch strobe (only acted on in IDLE)
//   i_req_ready         iDMA request ready
//   i_rsp_valid         iDMA response valid
//   i_rsp_ready_flag    software RSP_READY flag
//   o_state             current FSM state
//   o_req_valid         iDMA request valid (registered)
//   o_rsp_ready         iDMA response ready
//   o_rsp_fire          response accepted this cycle
module eth_idma_cfg_handshake
    import eth_idma_cfg_pkg::*;
(
    input  logic       s_clk,
    input  logic       s_rst_n,
    input  logic       i_launch,
    input  logic       i_req_ready,
    input  logic       i_rsp_valid,
    input  logic       i_rsp_ready_flag,
    output cfg_state_e o_state,
    output logic       o_req_valid,
    output logic       o_rsp_ready,
    output logic       o_rsp_fire
);

    cfg_state_e r_state;
    logic       r_req_valid;

    // Responses are only accepted while waiting for one, and only once
    // software has raised its ready flag.
    assign o_rsp_ready = (r_state == ST_WAIT_RSP) && i_rsp_ready_flag;
    assign o_rsp_fire  = o_rsp_ready && i_rsp_valid;
    assign o_state     = r_state;
    assign o_req_valid = r_req_valid;

    always_ff @(posedge s_clk or posedge s_rst_n) begin
        if (s_rst_n) begin
            r_state     <= ST_IDLE;
            r_req_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_launch) begin
                        r_state     <= ST_REQ;
                        r_req_valid <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (i_req_ready) begin
                        r_state     <= ST_WAIT_RSP;
                        r_req_valid <= 1'b0;
                    end
                end
                ST_WAIT_RSP: begin
                    if (o_rsp_fire) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/eth_idma_cfg_regs.sv
// eth_idma_cfg_regs
// Register-bus configuration block for an Ethernet iDMA front end: MAC
// address/config registers, a transfer descriptor, launch/response control
// and sticky status. Access is single-cycle (ready mirrors valid).
// Ports:
//   s_clk, s_rst_n                clock, asynchronous active-high reset
//   reg_req_i / reg_rsp_o         register-bus request / response
//   idma_req_o, idma_req_valid_o, idma_req_ready_i   iDMA request channel
//   idma_rsp_valid_i, idma_rsp_ready_o, idma_rsp_error_i  iDMA response
//   mac_addr_o, mac_cfg_o         MAC address and MAC config bits
//   busy_o                        transfer in progress
// Optional feature: define ETH_IDMA_CFG_XFER_CNT_EN to add the read-only
// completed-transfer counter at 0x48 (otherwise 0x48 is unmapped).
module eth_idma_cfg_regs
    import eth_idma_cfg_pkg::*;
#(
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned TFLenWidth = 32,
    parameter int unsigned RegAw      = 32,
    parameter int unsigned RegDw      = 32,
    parameter type reg_req_t  = eth_idma_cfg_pkg::reg_req_t,
    parameter type reg_rsp_t  = eth_idma_cfg_pkg::reg_rsp_t,
    parameter type idma_req_t = eth_idma_cfg_pkg::idma_req_t
) (
    input  logic        s_clk,
    input  logic        s_rst_n,
    input  reg_req_t    reg_req_i,
    output reg_rsp_t    reg_rsp_o,
    output idma_req_t   idma_req_o,
    output logic        idma_req_valid_o,
    input  logic        idma_req_ready_i,
    input  logic        idma_rsp_valid_i,
    output logic        idma_rsp_ready_o,
    input  logic        idma_rsp_error_i,
    output logic [47:0] mac_addr_o,
    output logic [15:0] mac_cfg_o,
    output logic        busy_o
);

    logic [RegDw-1:0] r_mac_lo, r_mac_hi, r_src, r_dst, r_len;
    logic [2:0]       r_src_prot, r_dst_prot;
    logic             r_rsp_flag, r_done, r_err;

    cfg_state_e       w_state;
    logic             w_req_valid, w_rsp_fire, w_launch;
    logic [RegAw-1:0] w_addr;
    logic [RegDw-1:0] w_wmask, w_rdata;
    logic             w_mapped, w_ro, w_desc, w_err, w_wr_ok;

    assign w_addr = reg_req_i.addr;

    // Byte-lane write mask from wstrb
    for (genvar gi = 0; gi < RegDw / 8; gi++) begin : g_bmask
        assign w_wmask[gi*8 +: 8] = {8{reg_req_i.wstrb[gi]}};
    end

    function automatic logic [RegDw-1:0] merge(input logic [RegDw-1:0] old_val,
                                               input logic [RegDw-1:0] wdata,
                                               input logic [RegDw-1:0] mask);
        return (old_val & ~mask) | (wdata & mask);
    endfunction

    function automatic logic is_addr(input logic [RegAw-1:0] addr, input logic [7:0] off);
        return addr == RegAw'(off);
    endfunction

`ifdef ETH_IDMA_CFG_XFER_CNT_EN
    logic [31:0] r_xfer_cnt;

    always_ff @(posedge s_clk or posedge s_rst_n) begin
        if (s_rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_rsp_fire && (r_xfer_cnt != 32'hFFFF_FFFF)) begin
            r_xfer_cnt <= r_xfer_cnt + 32'd1;
        end
    end
`endif

    // Address decode and read mux
    always_comb begin
        w_rdata  = '0;
        w_mapped = 1'b1;
        w_ro     = 1'b0;
        w_desc   = 1'b0;
        if      (is_addr(w_addr, OFF_MAC_LO))    w_rdata = r_mac_lo;
        else if (is_addr(w_addr, OFF_MAC_HI))    w_rdata = r_mac_hi;
        else if (is_addr(w_addr, OFF_SRC_ADDR)) begin w_rdata = r_src; w_desc = 1'b1; end
        else if (is_addr(w_addr, OFF_DST_ADDR)) begin w_rdata = r_dst; w_desc = 1'b1; end
        else if (is_addr(w_addr, OFF_LENGTH))   begin w_rdata = r_len; w_desc = 1'b1; end
        else if (is_addr(w_addr, OFF_SRC_PROT)) begin w_rdata = RegDw'(r_src_prot); w_desc = 1'b1; end
        else if (is_addr(w_addr, OFF_DST_PROT)) begin w_rdata = RegDw'(r_dst_prot); w_desc = 1'b1; end
        else if (is_addr(w_addr, OFF_REQ_VALID)) w_rdata = RegDw'(w_req_valid);
        else if (is_addr(w_addr, OFF_REQ_READY)) begin
            w_rdata = RegDw'(w_state == ST_IDLE);
            w_ro    = 1'b1;
        end
        else if (is_addr(w_addr, OFF_RSP_READY)) w_rdata = RegDw'(r_rsp_flag);
        else if (is_addr(w_addr, OFF_STATUS))    w_rdata = RegDw'({r_err, r_done});
`ifdef ETH_IDMA_CFG_XFER_CNT_EN
        else if (is_addr(w_addr, OFF_XFER_CNT)) begin
            w_rdata = RegDw'(r_xfer_cnt);
            w_ro    = 1'b1;
        end
`endif
        else w_mapped = 1'b0;
    end

    // Descriptor is frozen while a transfer is in flight.
    assign w_err = reg_req_i.valid &&
                   (!w_mapped ||
                    (reg_req_i.write && w_ro) ||
                    (reg_req_i.write && w_desc && (w_state != ST_IDLE)));
    assign w_wr_ok  = reg_req_i.valid && reg_req_i.write && !w_err;
    assign w_launch = w_wr_ok && is_addr(w_addr, OFF_REQ_VALID) &&
                      reg_req_i.wdata[0] && reg_req_i.wstrb[0];

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = w_err ? '0 : w_rdata;
        reg_rsp_o.error = w_err;
        reg_rsp_o.ready = reg_req_i.valid;
    end

    always_ff @(posedge s_clk or posedge s_rst_n) begin
        if (s_rst_n) begin
            r_mac_lo   <= '0;
            r_mac_hi   <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_src_prot <= '0;
            r_dst_prot <= '0;
            r_rsp_flag <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_wr_ok && is_addr(w_addr, OFF_MAC_LO))   r_mac_lo <= merge(r_mac_lo, reg_req_i.wdata, w_wmask);
            if (w_wr_ok && is_addr(w_addr, OFF_MAC_HI))   r_mac_hi <= merge(r_mac_hi, reg_req_i.wdata, w_wmask);
            if (w_wr_ok && is_addr(w_addr, OFF_SRC_ADDR)) r_src    <= merge(r_src, reg_req_i.wdata, w_wmask);
            if (w_wr_ok && is_addr(w_addr, OFF_DST_ADDR)) r_dst    <= merge(r_dst, reg_req_i.wdata, w_wmask);
            if (w_wr_ok && is_addr(w_addr, OFF_LENGTH))   r_len    <= merge(r_len, reg_req_i.wdata, w_wmask);
            if (w_wr_ok && is_addr(w_addr, OFF_SRC_PROT))
                r_src_prot <= (r_src_prot & ~w_wmask[2:0]) | (reg_req_i.wdata[2:0] & w_wmask[2:0]);
            if (w_wr_ok && is_addr(w_addr, OFF_DST_PROT))
                r_dst_prot <= (r_dst_prot & ~w_wmask[2:0]) | (reg_req_i.wdata[2:0] & w_wmask[2:0]);

            // Accepted response drops the flag; a same-cycle software write overrides.
            if (w_rsp_fire) r_rsp_flag <= 1'b0;
            if (w_wr_ok && is_addr(w_addr, OFF_RSP_READY) && reg_req_i.wstrb[0])
                r_rsp_flag <= reg_req_i.wdata[0];

            // Sticky W1C status; hardware set takes priority over the clear.
            r_done <= (r_done && !(w_wr_ok && is_addr(w_addr, OFF_STATUS) && reg_req_i.wstrb[0] &&
                                   reg_req_i.wdata[STATUS_DONE_BIT])) || w_rsp_fire;
            r_err  <= (r_err && !(w_wr_ok && is_addr(w_addr, OFF_STATUS) && reg_req_i.wstrb[0] &&
                                  reg_req_i.wdata[STATUS_ERR_BIT])) || (w_rsp_fire && idma_rsp_error_i);
        end
    end

    eth_idma_cfg_handshake u_handshake (
        .s_clk            (s_clk),
        .s_rst_n          (s_rst_n),
        .i_launch         (w_launch),
        .i_req_ready      (idma_req_ready_i),
        .i_rsp_valid      (idma_rsp_valid_i),
        .i_rsp_ready_flag (r_rsp_flag),
        .o_state          (w_state),
        .o_req_valid      (w_req_valid),
        .o_rsp_ready      (idma_rsp_ready_o),
        .o_rsp_fire       (w_rsp_fire)
    );

    logic [AddrWidth-1:0]  w_src_addr, w_dst_addr;
    logic [TFLenWidth-1:0] w_length;

    assign w_src_addr = AddrWidth'(r_src);
    assign w_dst_addr = AddrWidth'(r_dst);
    assign w_length   = TFLenWidth'(r_len);

    always_comb begin
        idma_req_o              = '0;
        idma_req_o.src_addr     = w_src_addr;
        idma_req_o.dst_addr     = w_dst_addr;
        idma_req_o.length       = w_length;
        idma_req_o.src_protocol = r_src_prot;
        idma_req_o.dst_protocol = r_dst_prot;
    end

    assign idma_req_valid_o = w_req_valid;
    assign busy_o           = (w_state != ST_IDLE);
    assign mac_addr_o       = {r_mac_hi[15:0], r_mac_lo[31:0]};
    assign mac_cfg_o        = r_mac_hi[31:16];

endmodule

// File: doc/eth_idma_cfg_regs.md
ETH_IDMA_CFG_REGS -- requirements
Module: eth_idma_cfg_regs

Interface
REQ-001 Parameter AddrWidth, default 64, iDMA source/destination address width; registers zero-extended to it.
REQ-002 Parameter TFLenWidth, default 32, iDMA transfer length width.
REQ-003 Parameter RegAw, default 32, register-bus address width; RegDw, default 32, register-bus data width.
REQ-004 s_clk  in  1  clock; all state on rising edge.
REQ-005 s_rst_n  in  1  reset, asynchronous, active-high (asserted when 1).
REQ-006 reg_req_i  in  struct  register-bus request: addr[RegAw], write, wdata[RegDw], wstrb[RegDw/8], valid.
REQ-007 reg_rsp_o  out  struct  register-bus response: rdata[RegDw], error, ready.
REQ-008 idma_req_o  out  struct  src_addr, dst_addr, length, src_protocol[3], dst_protocol[3].
REQ-009 idma_req_valid_o  out  1 / idma_req_ready_i  in  1  iDMA request handshake.
REQ-010 idma_rsp_valid_i  in  1 / idma_rsp_ready_o  out  1 / idma_rsp_error_i  in  1  iDMA response handshake.
REQ-011 mac_addr_o  out  48  {MAC_HI[15:0], MAC_LO}; mac_cfg_o  out  16  MAC_HI[31:16]; busy_o  out  1  FSM not IDLE.

Function
REQ-012 Map: 0x00 MAC_LO RW; 0x04 MAC_HI RW; 0x10 SRC_ADDR RW; 0x14 DST_ADDR RW; 0x18 LENGTH RW; 0x1c SRC_PROT RW[2:0]; 0x20 DST_PROT RW[2:0]; 0x38 REQ_VALID; 0x3c REQ_READY RO; 0x40 RSP_READY; 0x44 STATUS.
REQ-013 reg_rsp_o.ready = reg_req_i.valid combinationally; rdata combinational from current state; single-cycle access, no wait states.
REQ-014 RW writes honour wstrb per byte; bits above a register's width read 0.
REQ-015 Unmapped address, or write to RO register: error=1, rdata=0, no state change.
REQ-016 FSM states IDLE, REQ, WAIT_RSP; reset state IDLE.
REQ-017 IDLE->REQ when 0x38 written with wdata[0]=1 and wstrb[0]=1; writes of 0 to 0x38 have no effect in any state.
REQ-018 REQ: idma_req_valid_o=1, idma_req_o stable from descriptor registers; REQ->WAIT_RSP on cycle idma_req_ready_i=1.
REQ-019 WAIT_RSP: idma_rsp_ready_o = RSP_READY flag; on idma_rsp_valid_i & idma_rsp_ready_o: STATUS.done<=1, STATUS.err<=idma_rsp_error_i, RSP_READY flag<=0, ->IDLE.
REQ-020 0x40 write wdata[0]=1 sets RSP_READY flag (any state); write 0 clears it; read returns flag.
REQ-021 0x3c reads 1 iff IDLE; 0x38 reads idma_req_valid_o.
REQ-022 STATUS: bit0 done, bit1 err, both sticky, write-1-to-clear; hardware set wins over simultaneous W1C.
REQ-023 Writes to 0x10-0x20 outside IDLE: error=1, register unchanged (descriptor frozen during transfer).
REQ-024 0x38 launch write while REQ/WAIT_RSP: ignored, error=0.
REQ-025 idma_rsp_valid_i in IDLE or REQ: ignored, idma_rsp_ready_o=0.

Reset
REQ-026 On s_rst_n=1: all registers 0, FSM IDLE, idma_req_valid_o=0, idma_rsp_ready_o=0, busy_o=0, mac_addr_o=0, mac_cfg_o=0.
REQ-027 Reset mid-transfer aborts immediately; no iDMA response afterwards is recorded.

Configuration
REQ-028 Macro ETH_IDMA_CFG_XFER_CNT_EN defined: 0x48 XFER_CNT RO, 32-bit, +1 per completed response, saturates at 0xFFFFFFFF, reset 0.
REQ-029 Macro undefined: no counter logic; 0x48 is unmapped (error=1, rdata=0).

Structure
REQ-030 Package eth_idma_cfg_pkg holds register offset localparams, FSM state enum, idma request struct typedef and STATUS bit indices.
REQ-031 One sub-module eth_idma_cfg_handshake implements the FSM and iDMA handshakes; top holds decode and register storage.

Verification
REQ-032 Write 0x00=0x98001032, 0x04=0x00002070 -> mac_addr_o=0x207098001032, mac_cfg_o=0, error=0.
REQ-033 Program SRC=0, DST=0, LEN=0x40, SRC_PROT=0, DST_PROT=5; write 0x38=1 with idma_req_ready_i low 3 cycles -> valid held 3 cycles with stable fields, 0x3c reads 0.
REQ-034 In WAIT_RSP write 0x40=1, pulse idma_rsp_valid_i with error=0 -> STATUS=0x1, FSM IDLE, 0x3c=1, 0x40 reads 0.
REQ-035 Write 0x18=0x80 during WAIT_RSP -> error=1, LENGTH stays 0x40; read 0x30 -> error=1, rdata=0.
REQ-036 Assert s_rst_n during REQ -> next cycle idma_req_valid_o=0, all registers 0; with macro, three completions -> 0x48 reads 3.
